dds_channel_scheduler: RTL and testbench

- Time-multiplexes one shared sin/cos DDS core between NUM_CH independent tone channels.
- Holds a phase accumulator, frequency tuning word (FTW) and phase offset per channel, and issues one phase word per cycle to the core, visiting enabled channels round-robin.
- Tracks the core's fixed pipeline latency with a tag delay line, so each sin/cos sample leaves with its channel index.
- Sits between the register/config interface and the dds core; all downstream per-channel consumers read its tagged output stream.

---
 rtl/dds_pkg.sv | 36 +++
 rtl/dds_tag_pipe.sv | 35 +++
 rtl/dds_channel_scheduler.sv | 148 ++++++++++++++
 tb/tb_dds_channel_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types, core latencies and the round-robin channel picker for the
// DDS channel scheduler.
package dds_pkg;

  localparam int DDS_LAT_PLAIN  = 4;
  localparam int DDS_LAT_TAYLOR = 6;
  localparam int PHASE_DW_DEF   = 16;
  localparam int RR_MAX_CH      = 16;

  typedef logic [PHASE_DW_DEF-1:0] t_phase;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } t_state;

  // First enabled channel at or after ptr, wrapping modulo num_ch.
  function automatic logic [3:0] rr_next(input logic [RR_MAX_CH-1:0] enable,
                                         input logic [3:0]           ptr,
                                         input int                   num_ch);
    int         idx;
    logic       found;
    logic [3:0] sel;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_CH; i++) begin
      idx = (int'(ptr) + i) % num_ch;
      if (!found && (i < num_ch) && enable[idx[3:0]]) begin
        sel   = idx[3:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/dds_tag_pipe.sv
// Fixed-depth shift register carrying {valid, channel} alongside the DDS core
// pipeline so each core sample can be matched to the channel that issued it.
module dds_tag_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dds_channel_scheduler.sv
// Time-multiplexes one sin/cos DDS core across NUM_CH tone channels, issuing
// one phase word per cycle round-robin and tagging returned samples by channel.
module dds_channel_scheduler
  import dds_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int PHASE_DW    = PHASE_DW_DEF,
  parameter int OUT_DW      = 16,
  parameter int DDS_LATENCY = DDS_LAT_PLAIN,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_wr_en,
  input  logic [CH_W-1:0]       cfg_wr_ch,
  input  logic                  cfg_wr_sel,
  input  logic [PHASE_DW-1:0]   cfg_wr_data,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic                  sync,
  output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
  output logic                  m_axis_phase_tvalid,
  input  logic [2*OUT_DW-1:0]   s_axis_dds_tdata,
  input  logic                  s_axis_dds_tvalid,
  output logic [2*OUT_DW-1:0]   m_axis_out_tdata,
  output logic [CH_W-1:0]       m_axis_out_tuser,
  output logic                  m_axis_out_tvalid,
  output logic                  err_tag
);

  t_state              state_q, state_d;
  logic [PHASE_DW-1:0] acc_q  [NUM_CH];
  logic [PHASE_DW-1:0] acc_d  [NUM_CH];
  logic [PHASE_DW-1:0] ftw_q  [NUM_CH];
  logic [PHASE_DW-1:0] ftw_d  [NUM_CH];
  logic [PHASE_DW-1:0] poff_q [NUM_CH];
  logic [PHASE_DW-1:0] poff_d [NUM_CH];
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [PHASE_DW-1:0] phase_data_q, phase_data_d;
  logic                phase_vld_q, phase_vld_d;
  logic [CH_W-1:0]     phase_ch_q, phase_ch_d;
  logic [2*OUT_DW-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]     out_user_q, out_user_d;
  logic                out_vld_q, out_vld_d;
  logic                err_q, err_d;
  logic [CH_W-1:0]     sel_ch;
  logic                issue;
  logic [CH_W:0]       tag_out;

  assign sel_ch = CH_W'(rr_next(RR_MAX_CH'(ch_enable), 4'(ptr_q), NUM_CH));
  // A sync cycle and the cycle enables drop to zero both suppress the issue.
  assign issue  = (state_q == ST_RUN) && (|ch_enable) && !sync;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_d        = ftw_q;
    poff_d       = poff_q;
    ptr_d        = ptr_q;
    phase_data_d = phase_data_q;
    phase_vld_d  = issue;
    phase_ch_d   = phase_ch_q;

    case (state_q)
      ST_IDLE: if (|ch_enable) state_d = ST_RUN;
      ST_RUN:  if (ch_enable == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (sync) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_d[i] = '0;
      end
      ptr_d = '0;
    end else if (issue) begin
      phase_data_d  = acc_q[sel_ch] + poff_q[sel_ch];
      phase_ch_d    = sel_ch;
      acc_d[sel_ch] = acc_q[sel_ch] + ftw_q[sel_ch];
      ptr_d         = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + CH_W'(1);
    end

    // Writes land in the register file only, so an issue this cycle sees old values.
    if (cfg_wr_en && (int'(cfg_wr_ch) < NUM_CH)) begin
      if (cfg_wr_sel) poff_d[cfg_wr_ch] = cfg_wr_data;
      else            ftw_d[cfg_wr_ch]  = cfg_wr_data;
    end
  end

  dds_tag_pipe #(
    .DEPTH (DDS_LATENCY),
    .WIDTH (CH_W + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .din     ({phase_vld_q, phase_ch_q}),
    .dout    (tag_out)
  );

  always_comb begin
    out_data_d = out_data_q;
    out_user_d = out_user_q;
    out_vld_d  = s_axis_dds_tvalid;
    if (s_axis_dds_tvalid) begin
      out_data_d = s_axis_dds_tdata;
      out_user_d = tag_out[CH_W-1:0];
    end
    err_d = err_q | (s_axis_dds_tvalid != tag_out[CH_W]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]  <= '0;
        ftw_q[i]  <= '0;
        poff_q[i] <= '0;
      end
      ptr_q        <= '0;
      phase_data_q <= '0;
      phase_vld_q  <= 1'b0;
      phase_ch_q   <= '0;
      out_data_q   <= '0;
      out_user_q   <= '0;
      out_vld_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
      poff_q       <= poff_d;
      ptr_q        <= ptr_d;
      phase_data_q <= phase_data_d;
      phase_vld_q  <= phase_vld_d;
      phase_ch_q   <= phase_ch_d;
      out_data_q   <= out_data_d;
      out_user_q   <= out_user_d;
      out_vld_q    <= out_vld_d;
      err_q        <= err_d;
    end
  end

  assign m_axis_phase_tdata  = phase_data_q;
  assign m_axis_phase_tvalid = phase_vld_q;
  assign m_axis_out_tdata    = out_data_q;
  assign m_axis_out_tuser    = out_user_q;
  assign m_axis_out_tvalid   = out_vld_q;
  assign err_tag             = err_q;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Directed bench for dds_channel_scheduler with a delay-line stand-in for the
// DDS core that returns {phase, ~phase} DDS_LATENCY cycles after each issue.
module tb_dds_channel_scheduler;

  localparam int NCH = 4;
  localparam int LAT = 4;
  localparam int CHW = 2;

  logic        clk;
  logic        reset_n;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_ch;
  logic        cfg_wr_sel;
  logic [15:0] cfg_wr_data;
  logic [3:0]  ch_enable;
  logic        sync;
  logic [15:0] m_axis_phase_tdata;
  logic        m_axis_phase_tvalid;
  logic [31:0] s_axis_dds_tdata;
  logic        s_axis_dds_tvalid;
  logic [31:0] m_axis_out_tdata;
  logic [1:0]  m_axis_out_tuser;
  logic        m_axis_out_tvalid;
  logic        err_tag;

  dds_channel_scheduler #(
    .NUM_CH      (NCH),
    .PHASE_DW    (16),
    .OUT_DW      (16),
    .DDS_LATENCY (LAT)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cfg_wr_en           (cfg_wr_en),
    .cfg_wr_ch           (cfg_wr_ch),
    .cfg_wr_sel          (cfg_wr_sel),
    .cfg_wr_data         (cfg_wr_data),
    .ch_enable           (ch_enable),
    .sync                (sync),
    .m_axis_phase_tdata  (m_axis_phase_tdata),
    .m_axis_phase_tvalid (m_axis_phase_tvalid),
    .s_axis_dds_tdata    (s_axis_dds_tdata),
    .s_axis_dds_tvalid   (s_axis_dds_tvalid),
    .m_axis_out_tdata    (m_axis_out_tdata),
    .m_axis_out_tuser    (m_axis_out_tuser),
    .m_axis_out_tvalid   (m_axis_out_tvalid),
    .err_tag             (err_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in core: fixed-latency pipe sharing reset_n with the scheduler.
  logic        core_vld [LAT];
  logic [15:0] core_ph  [LAT];
  logic        force_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        core_vld[i] <= 1'b0;
        core_ph[i]  <= '0;
      end
    end else begin
      core_vld[0] <= m_axis_phase_tvalid;
      core_ph[0]  <= m_axis_phase_tdata;
      for (int i = 1; i < LAT; i++) begin
        core_vld[i] <= core_vld[i-1];
        core_ph[i]  <= core_ph[i-1];
      end
    end
  end

  assign s_axis_dds_tvalid = core_vld[LAT-1] | force_vld;
  assign s_axis_dds_tdata  = {core_ph[LAT-1], ~core_ph[LAT-1]};

  typedef struct {
    int          ch;
    logic [15:0] ph;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  int          cyc;
  logic        sb_en;
  logic [15:0] acc_m  [NCH];
  logic [15:0] ftw_m  [NCH];
  logic [15:0] poff_m [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0 && (q[0].cyc + LAT + 1) == cyc) begin
      e = q.pop_front();
      chk("out_vld", 64'(m_axis_out_tvalid), 64'd1);
      chk("out_user", 64'(m_axis_out_tuser), 64'(e.ch));
      chk("out_data", 64'(m_axis_out_tdata), 64'({e.ph, ~e.ph}));
    end else if (sb_en) begin
      chk("out_idle", 64'(m_axis_out_tvalid), 64'd0);
    end
  endtask

  task automatic idle_tick();
    tick();
    chk("no_issue", 64'(m_axis_phase_tvalid), 64'd0);
  endtask

  task automatic issue(input int ch);
    exp_t        e;
    logic [15:0] ph;
    ph = acc_m[ch] + poff_m[ch];
    tick();
    chk("phase_vld", 64'(m_axis_phase_tvalid), 64'd1);
    chk("phase_data", 64'(m_axis_phase_tdata), 64'(ph));
    acc_m[ch] = acc_m[ch] + ftw_m[ch];
    e.ch  = ch;
    e.ph  = ph;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic cfg_write(input int ch, input logic sel, input logic [15:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_ch   = 2'(ch);
    cfg_wr_sel  = sel;
    cfg_wr_data = data;
    tick();
    cfg_wr_en   = 1'b0;
    if (sel) poff_m[ch] = data;
    else     ftw_m[ch]  = data;
  endtask

  task automatic drain();
    ch_enable = '0;
    idle_tick();
    repeat (LAT + 2) tick();
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    idle_tick();
    sync = 1'b0;
    for (int i = 0; i < NCH; i++) acc_m[i] = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      acc_m[i]  = '0;
      ftw_m[i]  = '0;
      poff_m[i] = '0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ph"},   64'(m_axis_phase_tdata),  64'd0);
    chk({tag, "_phv"},  64'(m_axis_phase_tvalid), 64'd0);
    chk({tag, "_od"},   64'(m_axis_out_tdata),    64'd0);
    chk({tag, "_ou"},   64'(m_axis_out_tuser),    64'd0);
    chk({tag, "_ov"},   64'(m_axis_out_tvalid),   64'd0);
    chk({tag, "_err"},  64'(err_tag),             64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; sb_en = 1'b1;
    reset_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_ch = '0; cfg_wr_sel = 1'b0;
    cfg_wr_data = '0; ch_enable = '0; sync = 1'b0; force_vld = 1'b0;
    model_clear();

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Single channel, ftw 0x1000
    cfg_write(0, 1'b0, 16'h1000);
    ch_enable = 4'b0001;
    idle_tick();
    issue(0);
    chk("t1_first", 64'(m_axis_phase_tdata), 64'h0000);
    issue(0);
    chk("t1_second", 64'(m_axis_phase_tdata), 64'h1000);
    repeat (5) issue(0);
    chk("t1_seventh", 64'(m_axis_phase_tdata), 64'h6000);
    drain();

    // Wrap on channel 1
    sync_pulse();
    cfg_write(1, 1'b0, 16'hC000);
    ch_enable = 4'b0010;
    idle_tick();
    repeat (4) issue(1);
    chk("wrap_4th", 64'(m_axis_phase_tdata), 64'h4000);
    issue(1);
    chk("wrap_5th", 64'(m_axis_phase_tdata), 64'h0000);
    drain();

    // Round robin over four channels, ch0 offset 0x0123
    sync_pulse();
    cfg_write(0, 1'b0, 16'h0100);
    cfg_write(1, 1'b0, 16'h0200);
    cfg_write(2, 1'b0, 16'h0300);
    cfg_write(3, 1'b0, 16'h0400);
    cfg_write(0, 1'b1, 16'h0123);
    cfg_write(1, 1'b1, 16'h0000);
    ch_enable = 4'b1111;
    idle_tick();
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < NCH; c++) issue(c);
    end
    chk("rr_ch3_v2", 64'(m_axis_phase_tdata), 64'h0800);

    // ftw0 write coincident with a ch0 issue
    cfg_wr_en = 1'b1; cfg_wr_ch = 2'd0; cfg_wr_sel = 1'b0; cfg_wr_data = 16'h1000;
    issue(0);
    cfg_wr_en = 1'b0;
    ftw_m[0] = 16'h1000;
    chk("wr_same_cycle", 64'(m_axis_phase_tdata), 64'h0423);
    for (int c = 1; c < NCH; c++) issue(c);
    issue(0);
    chk("wr_old_step", 64'(m_axis_phase_tdata), 64'h0523);
    for (int c = 1; c < NCH; c++) issue(c);
    issue(0);
    chk("wr_new_step", 64'(m_axis_phase_tdata), 64'h1523);

    // ch2 disabled, then resumed from its held accumulator
    ch_enable = 4'b1011;
    issue(1); issue(3); issue(0);
    issue(1); issue(3); issue(0);
    ch_enable = 4'b1111;
    issue(1);
    issue(2);
    chk("ch2_resume", 64'(m_axis_phase_tdata), 64'h0F00);
    issue(3); issue(0); issue(1);

    // sync mid-run: no issue, restart at ch0 with phase = poff0
    sync_pulse();
    issue(0);
    chk("sync_ch0", 64'(m_axis_phase_tdata), 64'h0123);
    issue(1); issue(2); issue(3);
    drain();

    // Core valid without a tag
    chk("err_before", 64'(err_tag), 64'd0);
    sb_en = 1'b0;
    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    tick();
    chk("err_set", 64'(err_tag), 64'd1);
    repeat (3) tick();
    chk("err_sticky", 64'(err_tag), 64'd1);
    sb_en = 1'b1;

    // Reset mid-run, then a fresh start
    ch_enable = 4'b1111;
    idle_tick();
    issue(0); issue(1); issue(2);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    q.delete();
    model_clear();
    ch_enable = '0;
    tick();
    reset_n = 1'b1;
    tick();
    cfg_write(0, 1'b0, 16'h1000);
    ch_enable = 4'b0001;
    idle_tick();
    issue(0);
    chk("fresh_first", 64'(m_axis_phase_tdata), 64'h0000);
    issue(0);
    issue(0);
    chk("fresh_third", 64'(m_axis_phase_tdata), 64'h2000);
    drain();
    chk("fresh_err", 64'(err_tag), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
